pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-address sequencer that consumes the branch condition unit's `bcres` together with decode-stage control-transfer information and produces the next fetch PC. It sits between decode and the instruction-fetch stage. It implements MIPS single-delay-slot semantics and holds a resolved redirect across fetch stalls until the delay-slot fetch completes. It also produces the link address for `jal`, `jalr`, `bltzal` and `bgezal`.

## Interface
- `RESET_VECTOR`, 32'hBFC0_0000, PC loaded by reset.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_if` in 1: fetch cannot complete this cycle; PC must hold.
- `id_fire` in 1: decode instruction is valid and advances this cycle.
- `id_pc` in 32: PC of the decode-stage instruction.
- `br_en` in 1: decode instruction is a conditional branch.
- `bcres` in 1: branch condition result from the condition unit, same cycle.
- `br_imm` in 16: branch offset field.
- `j_en` in 1: `j`/`jal`.
- `j_idx` in 26: jump index field.
- `jr_en` in 1: `jr`/`jalr`.
- `jr_target` in 32: forwarded register target.
- `pc` out 32: current fetch address.
- `pc_valid` out 1: fetch request valid.
- `link_addr` out 32: `id_pc + 8`, combinational.
- `redirect` out 1: registered one-cycle pulse, high in the cycle `pc` first shows a redirect target.
- `misalign_err` out 1: sticky flag for a `jr_target` whose bits [1:0] are not 00.

## Operation
- `taken = id_fire & (jr_en | j_en | (br_en & bcres))`.
- Target priority when several enables are high: `jr_en` > `j_en` > `br_en`.
- Branch target: `id_pc + 4 + sext(br_imm) << 2`, modulo 2^32.
- Jump target: `{(id_pc+4)[31:28], j_idx, 2'b00}`.
- JR target: `jr_target & ~32'h3`. When `jr_target[1:0] != 0`, set `misalign_err`; it stays set until `rst`.
- State machine, RUN (reset state) and HOLD:
  - RUN, no taken, `!stall_if`: `pc <= pc + 4`, wrapping 32'hFFFF_FFFC to 0.
  - RUN, no taken, `stall_if`: `pc` holds.
  - RUN, taken, `!stall_if`: the delay slot completes this cycle. `pc <= target`, `redirect <= 1`, stay RUN.
  - RUN, taken, `stall_if`: `pend <= target`, go to HOLD, `pc` holds.
  - HOLD, `stall_if`: hold `pc` and `pend`.
  - HOLD, `!stall_if`: `pc <= pend`, `redirect <= 1`, go to RUN.
  - HOLD, `taken`: protocol violation. It is ignored and `pend` is unchanged.
- Branch in a delay slot: handled in RUN like any other transfer. Its target overrides the sequential PC.
- `link_addr` is valid whenever `id_pc` is valid; no gating.

## Timing
- Reset values: `pc = RESET_VECTOR`, `pc_valid = 0`, `redirect = 0`, `misalign_err = 0`, state RUN, `pend = 0`.
- `pc_valid` goes to 1 on the first edge with `rst` low and stays 1.
- Redirect latency: the target appears on `pc` one edge after the cycle in which `taken` and `!stall_if` are both true, whether in RUN or HOLD.
- No flush is produced; the delay slot always executes.
- `rst` in HOLD discards `pend`; no `redirect` pulse follows.
- `misalign_err` is set on the edge after the offending `taken`.

## Structure
- Shared package `pc_seq_pkg` holds:
  - the default `RESET_VECTOR` value;
  - the 1-bit state enum (RUN/HOLD);
  - the `INSN_BYTES = 4` constant.
- One combinational sub-module, `branch_target_calc`:
  - inputs: `id_pc`, `br_imm`, `j_idx`, `jr_target`, enables;
  - outputs: `target`, `misalign`.
- The sequencer owns all registers.

## Test plan
- Reset release with `stall_if = 0`: `pc` reads 32'hBFC0_0000, then 32'hBFC0_0004, then 32'hBFC0_0008. `pc_valid` rises one edge after `rst` falls.
- `id_pc = 32'h0000_1000`, `br_en = 1`, `bcres = 1`, `br_imm = 16'hFFFF`, no stall: the next `pc` is 32'h0000_1000 with a one-cycle `redirect`. With `bcres = 0`, `pc` advances by 4 and there is no `redirect`.
- Taken `j` at `id_pc = 32'h1000_0000`, `j_idx = 26'h3`, with `stall_if` held for 3 cycles: `pc` holds for those 3 cycles, then becomes 32'h1000_000C, with `redirect` high for exactly one cycle.
- `jr_target = 32'h0000_2002`: `pc` becomes 32'h0000_2000 and `misalign_err` sets and stays set across later jumps until `rst`.
- Enter HOLD, then assert `rst` while still stalled: `pc` returns to `RESET_VECTOR`, no `redirect` pulse, the pending target is never fetched.
- PC wrap: at `pc = 32'hFFFF_FFFC` with no stall, the next `pc` is 0. `jr_en` and `br_en` high together: the `jr` target wins.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-address sequencer: reset vector default,
// instruction size and the sequencer state encoding.
package pc_seq_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam int unsigned INSN_BYTES           = 4;

  // RUN: sequential fetch or immediate redirect.
  // HOLD: a redirect target is parked while fetch is stalled.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } seq_state_e;

endpackage : pc_seq_pkg

// File: rtl/branch_target_calc.sv
// Combinational control-transfer target selection for the decode-stage
// instruction. Priority is jr > j > conditional branch.
module branch_target_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] id_pc,
  input  logic [15:0] br_imm,
  input  logic [25:0] j_idx,
  input  logic [31:0] jr_target,
  input  logic        br_en,
  input  logic        j_en,
  input  logic        jr_en,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;

  assign pc_plus4  = id_pc + 32'(INSN_BYTES);
  assign br_offset = {{14{br_imm[15]}}, br_imm, 2'b00};

  // Flag a register target that is not word aligned; the low bits are dropped.
  assign misalign = jr_en & (jr_target[1:0] != 2'b00);

  // Select the target of the highest-priority enabled transfer.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives target, so no latch is inferred.
    target = pc_plus4;
    if (jr_en) begin
      target = jr_target & ~32'h3;
    end else if (j_en) begin
      target = {pc_plus4[31:28], j_idx, 2'b00};
    end else if (br_en) begin
      target = pc_plus4 + br_offset;
    end
  end

endmodule : branch_target_calc

// File: rtl/pc_sequencer.sv
// Next-fetch-PC sequencer with MIPS single delay slot semantics. A resolved
// redirect is parked in pend_q while fetch is stalled and released when the
// delay-slot fetch completes.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        id_fire,
  input  logic [31:0] id_pc,
  input  logic        br_en,
  input  logic        bcres,
  input  logic [15:0] br_imm,
  input  logic        j_en,
  input  logic [25:0] j_idx,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic [31:0] link_addr,
  output logic        redirect,
  output logic        misalign_err
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        redirect_q, redirect_d;
  logic        misalign_q, misalign_d;
  logic        valid_q;

  logic        taken;
  logic [31:0] target;
  logic        misalign;

  assign taken = id_fire & (jr_en | j_en | (br_en & bcres));

  branch_target_calc u_target (
    .id_pc     (id_pc),
    .br_imm    (br_imm),
    .j_idx     (j_idx),
    .jr_target (jr_target),
    .br_en     (br_en),
    .j_en      (j_en),
    .jr_en     (jr_en),
    .target    (target),
    .misalign  (misalign)
  );

  // Next-state logic: sequential advance, immediate redirect, or park/release.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    redirect_d = 1'b0;
    misalign_d = misalign_q;
    case (state_q)
      ST_RUN: begin
        if (taken) begin
          misalign_d = misalign_q | misalign;
          if (!stall_if) begin
            pc_d       = target;
            redirect_d = 1'b1;
          end else begin
            pend_d  = target;
            state_d = ST_HOLD;
          end
        end else if (!stall_if) begin
          pc_d = pc_q + 32'(INSN_BYTES);
        end
      end
      ST_HOLD: begin
        // A new transfer while parked is a protocol violation and is ignored.
        if (!stall_if) begin
          pc_d       = pend_q;
          redirect_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State register with synchronous reset; reset also discards any parked target.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      pend_q     <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      valid_q    <= 1'b1;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = valid_q;
  assign redirect     = redirect_q;
  assign misalign_err = misalign_q;
  assign link_addr    = id_pc + 32'(2 * INSN_BYTES);

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each directed step pushes the
// hand-computed post-edge outputs; a monitor pops and compares after each edge.
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic        redirect;
    logic        valid;
    logic        mis;
    logic [31:0] link;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        id_fire;
  logic [31:0] id_pc;
  logic        br_en;
  logic        bcres;
  logic [15:0] br_imm;
  logic        j_en;
  logic [25:0] j_idx;
  logic        jr_en;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] link_addr;
  logic        redirect;
  logic        misalign_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall_if     (stall_if),
    .id_fire      (id_fire),
    .id_pc        (id_pc),
    .br_en        (br_en),
    .bcres        (bcres),
    .br_imm       (br_imm),
    .j_en         (j_en),
    .j_idx        (j_idx),
    .jr_en        (jr_en),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .link_addr    (link_addr),
    .redirect     (redirect),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: after every rising edge compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",           pc,                  e.pc);
        check("redirect",     {31'd0, redirect},     {31'd0, e.redirect});
        check("pc_valid",     {31'd0, pc_valid},     {31'd0, e.valid});
        check("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
        check("link_addr",    link_addr,           e.link);
      end
    end
  end

  // One cycle of stimulus; expectations describe outputs after the next edge.
  task automatic step(input logic r, input logic st, input logic fire, input logic [31:0] ipc,
                      input logic ben, input logic bc, input logic [15:0] imm,
                      input logic jen, input logic [25:0] idx,
                      input logic jren, input logic [31:0] jrt,
                      input logic [31:0] e_pc, input logic e_red, input logic e_val,
                      input logic e_mis);
    exp_t e;
    @(negedge clk);
    rst = r; stall_if = st; id_fire = fire; id_pc = ipc;
    br_en = ben; bcres = bc; br_imm = imm;
    j_en = jen; j_idx = idx; jr_en = jren; jr_target = jrt;
    e.pc = e_pc; e.redirect = e_red; e.valid = e_val; e.mis = e_mis;
    e.link = ipc + 32'd8;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; stall_if = 1'b0; id_fire = 1'b0; id_pc = '0;
    br_en = 1'b0; bcres = 1'b0; br_imm = '0; j_en = 1'b0; j_idx = '0;
    jr_en = 1'b0; jr_target = '0;

    //    rst st fire id_pc         br bc imm       j  idx       jr jr_target     exp_pc        red val mis
    // Reset state, then release: RV -> RV+4 -> RV+8, valid rises on first edge out of reset.
    step(1, 0, 0, 32'h0000_0000, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         RV,           0, 0, 0);
    step(1, 0, 0, 32'h0000_0000, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         RV,           0, 0, 0);
    step(0, 0, 0, 32'h0000_0000, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'hBFC0_0004, 0, 1, 0);
    step(0, 0, 0, 32'h0000_0000, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'hBFC0_0008, 0, 1, 0);
    // Backward branch to itself: 0x1004 - 4 = 0x1000, one-cycle redirect.
    step(0, 0, 1, 32'h0000_1000, 1, 1, 16'hFFFF, 0, 26'h0,    0, 32'h0,         32'h0000_1000, 1, 1, 0);
    // Same branch not taken: sequential advance, no redirect.
    step(0, 0, 1, 32'h0000_1000, 1, 0, 16'hFFFF, 0, 26'h0,    0, 32'h0,         32'h0000_1004, 0, 1, 0);
    step(0, 0, 0, 32'h0000_1004, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'h0000_1008, 0, 1, 0);
    // Taken j under a 3-cycle stall: pc holds, then jumps to 0x1000_000C.
    step(0, 1, 1, 32'h1000_0000, 0, 0, 16'h0000, 1, 26'h3,    0, 32'h0,         32'h0000_1008, 0, 1, 0);
    step(0, 1, 0, 32'h1000_0000, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'h0000_1008, 0, 1, 0);
    step(0, 1, 0, 32'h1000_0000, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'h0000_1008, 0, 1, 0);
    step(0, 0, 0, 32'h1000_0004, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'h1000_000C, 1, 1, 0);
    step(0, 0, 0, 32'h1000_0008, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'h1000_0010, 0, 1, 0);
    // Misaligned jr: low bits dropped, sticky error survives later jumps.
    step(0, 0, 1, 32'h1000_0010, 0, 0, 16'h0000, 0, 26'h0,    1, 32'h0000_2002, 32'h0000_2000, 1, 1, 1);
    step(0, 0, 1, 32'h0000_2000, 0, 0, 16'h0000, 1, 26'h40,   0, 32'h0,         32'h0000_0100, 1, 1, 1);
    step(0, 0, 0, 32'h0000_2004, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'h0000_0104, 0, 1, 1);
    // Park a j target, ignore a second transfer in HOLD, then reset while stalled.
    step(0, 1, 1, 32'h0000_0104, 0, 0, 16'h0000, 1, 26'h100,  0, 32'h0,         32'h0000_0104, 0, 1, 1);
    step(0, 1, 1, 32'h0000_0104, 0, 0, 16'h0000, 0, 26'h0,    1, 32'h0000_8000, 32'h0000_0104, 0, 1, 1);
    step(1, 1, 0, 32'h0000_0104, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         RV,           0, 0, 0);
    step(0, 0, 0, 32'h0000_0104, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'hBFC0_0004, 0, 1, 0);
    // HOLD ignores a jr and later releases the original j target B000_0080.
    step(0, 1, 1, 32'hBFC0_0004, 0, 0, 16'h0000, 1, 26'h20,   0, 32'h0,         32'hBFC0_0004, 0, 1, 0);
    step(0, 1, 1, 32'hBFC0_0004, 0, 0, 16'h0000, 0, 26'h0,    1, 32'h0000_3000, 32'hBFC0_0004, 0, 1, 0);
    step(0, 0, 0, 32'hBFC0_0008, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'hB000_0080, 1, 1, 0);
    // PC wrap from FFFF_FFFC to 0.
    step(0, 0, 1, 32'hB000_0080, 0, 0, 16'h0000, 0, 26'h0,    1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 0);
    step(0, 0, 0, 32'hB000_0084, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'h0000_0000, 0, 1, 0);
    // Priority: jr beats branch, j beats branch.
    step(0, 0, 1, 32'h0000_0000, 1, 1, 16'h0010, 0, 26'h0,    1, 32'h0000_5000, 32'h0000_5000, 1, 1, 0);
    step(0, 0, 1, 32'h0000_5000, 1, 1, 16'h0001, 1, 26'h10,   0, 32'h0,         32'h0000_0040, 1, 1, 0);
    // Plain stall holds; enables without id_fire are not taken.
    step(0, 1, 0, 32'h0000_0040, 0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,         32'h0000_0040, 0, 1, 0);
    step(0, 0, 0, 32'h0000_0040, 1, 1, 16'h0010, 1, 26'h55,   1, 32'h0000_7000, 32'h0000_0044, 0, 1, 0);

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_sequencer
